irrigation_countdown: RTL and testbench

//  Down-counting BCD MM:SS timer for one irrigation zone; complement of the up-counting

---
 rtl/irrigation_countdown.sv | 158 +++++++++++++++
 tb/tb_irrigation_countdown.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_countdown.sv
// Down-counting BCD MM:SS irrigation zone timer with valve enable and done pulse.
// Loaded with a duration, decrements on each 1 Hz tick while running.
module irrigation_countdown #(
  parameter int unsigned MIN_TENS_MAX = 5,
  parameter bit          AUTO_RELOAD  = 1'b0
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_mt,
  input  logic [3:0] load_mu,
  input  logic [3:0] load_st,
  input  logic [3:0] load_su,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] mt,
  output logic [3:0] mu,
  output logic [3:0] st,
  output logic [3:0] su,
  output logic       running,
  output logic       valve_on,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_shadow;
  logic        r_running;
  logic        r_valve_on;
  logic        r_done;

  logic [15:0] w_load_val;
  logic [15:0] w_dec;
  logic        w_cnt_zero;
  logic        w_last;
  logic        w_shadow_zero;

  always_comb begin
    w_load_val[15:12] = (load_mt > 4'(MIN_TENS_MAX)) ? 4'(MIN_TENS_MAX) : load_mt;
    w_load_val[11:8]  = (load_mu > 4'd9) ? 4'd9 : load_mu;
    w_load_val[7:4]   = (load_st > 4'd5) ? 4'd5 : load_st;
    w_load_val[3:0]   = (load_su > 4'd9) ? 4'd9 : load_su;
  end

  // Borrow chain: su(mod 10) -> st(mod 6) -> mu(mod 10) -> mt.
  always_comb begin
    w_dec = r_cnt;
    if (r_cnt[3:0] != 4'd0) begin
      w_dec[3:0] = r_cnt[3:0] - 4'd1;
    end else begin
      w_dec[3:0] = 4'd9;
      if (r_cnt[7:4] != 4'd0) begin
        w_dec[7:4] = r_cnt[7:4] - 4'd1;
      end else begin
        w_dec[7:4] = 4'd5;
        if (r_cnt[11:8] != 4'd0) begin
          w_dec[11:8] = r_cnt[11:8] - 4'd1;
        end else begin
          w_dec[11:8]  = 4'd9;
          w_dec[15:12] = r_cnt[15:12] - 4'd1;
        end
      end
    end
  end

  assign w_cnt_zero    = (r_cnt == '0);
  assign w_last        = (r_cnt == 16'h0001);
  assign w_shadow_zero = (r_shadow == '0);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_running  <= 1'b0;
      r_valve_on <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_running  <= 1'b0;
        r_valve_on <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_PAUSED: begin
            if (pause) begin
              r_state <= r_state;
            end else if (start) begin
              if (!w_cnt_zero) begin
                r_state    <= S_RUN;
                r_running  <= 1'b1;
                r_valve_on <= 1'b1;
              end
            end else if (load) begin
              r_cnt    <= w_load_val;
              r_shadow <= w_load_val;
            end
          end
          S_RUN: begin
            // A tick arriving with pause is dropped, not deferred.
            if (pause) begin
              r_state    <= S_PAUSED;
              r_running  <= 1'b0;
              r_valve_on <= 1'b0;
            end else if (tick && !w_cnt_zero) begin
              r_cnt <= w_dec;
              if (w_last) begin
                r_state    <= S_DONE;
                r_done     <= 1'b1;
                r_running  <= 1'b0;
                r_valve_on <= 1'b0;
              end
            end
          end
          S_DONE: begin
            if (AUTO_RELOAD) begin
              if (!w_shadow_zero) begin
                r_cnt      <= r_shadow;
                r_state    <= S_RUN;
                r_running  <= 1'b1;
                r_valve_on <= 1'b1;
              end
            end else if (pause) begin
              r_state <= S_DONE;
            end else if (start) begin
              if (!w_shadow_zero) begin
                r_cnt      <= r_shadow;
                r_state    <= S_RUN;
                r_running  <= 1'b1;
                r_valve_on <= 1'b1;
              end
            end else if (load) begin
              r_cnt    <= w_load_val;
              r_shadow <= w_load_val;
              r_state  <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mt       = r_cnt[15:12];
  assign mu       = r_cnt[11:8];
  assign st       = r_cnt[7:4];
  assign su       = r_cnt[3:0];
  assign running  = r_running;
  assign valve_on = r_valve_on;
  assign done     = r_done;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Bench for irrigation_countdown: one hold-at-done and one auto-reload instance
// driven in parallel, compared every cycle against a seconds-based reference model.
module tb_irrigation_countdown;

  localparam int MTM = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic clear_n = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [3:0] load_mt = '0, load_mu = '0, load_st = '0, load_su = '0;

  logic [3:0] mt0, mu0, st0, su0, mt1, mu1, st1, su1;
  logic running0, valve0, done0, running1, valve1, done1;

  int n_cmp = 0;
  int n_mis = 0;
  int n_done0 = 0;
  int n_done1 = 0;

  int m_mode[2];
  int m_cnt[2];
  int m_sh[2];
  bit m_done[2];

  always #5 clk = ~clk;

  irrigation_countdown #(.MIN_TENS_MAX(MTM), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .clear_n(clear_n), .tick(tick), .load(load),
    .load_mt(load_mt), .load_mu(load_mu), .load_st(load_st), .load_su(load_su),
    .start(start), .pause(pause), .abort(abort),
    .mt(mt0), .mu(mu0), .st(st0), .su(su0),
    .running(running0), .valve_on(valve0), .done(done0)
  );

  irrigation_countdown #(.MIN_TENS_MAX(MTM), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .clear_n(clear_n), .tick(tick), .load(load),
    .load_mt(load_mt), .load_mu(load_mu), .load_st(load_st), .load_su(load_su),
    .start(start), .pause(pause), .abort(abort),
    .mt(mt1), .mu(mu1), .st(st1), .su(su1),
    .running(running1), .valve_on(valve1), .done(done1)
  );

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit cn, input bit tk, input bit ld, input logic [15:0] d,
                       input bit s, input bit p, input bit a);
    int lv;
    lv = (min_i(int'(d[15:12]), MTM) * 10 + min_i(int'(d[11:8]), 9)) * 60
       + min_i(int'(d[7:4]), 5) * 10 + min_i(int'(d[3:0]), 9);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (!cn) begin
        m_mode[i] = M_IDLE; m_cnt[i] = 0; m_sh[i] = 0;
      end else if (a) begin
        m_mode[i] = M_IDLE; m_cnt[i] = 0;
      end else begin
        case (m_mode[i])
          M_RUN: begin
            if (p) m_mode[i] = M_PAUSED;
            else if (tk && m_cnt[i] > 0) begin
              m_cnt[i] = m_cnt[i] - 1;
              if (m_cnt[i] == 0) begin m_mode[i] = M_DONE; m_done[i] = 1'b1; end
            end
          end
          M_DONE: begin
            if (i == 1) begin
              if (m_sh[i] != 0) begin m_cnt[i] = m_sh[i]; m_mode[i] = M_RUN; end
            end else if (!p) begin
              if (s) begin
                if (m_sh[i] != 0) begin m_cnt[i] = m_sh[i]; m_mode[i] = M_RUN; end
              end else if (ld) begin
                m_cnt[i] = lv; m_sh[i] = lv; m_mode[i] = M_IDLE;
              end
            end
          end
          default: begin
            if (!p) begin
              if (s) begin
                if (m_cnt[i] != 0) m_mode[i] = M_RUN;
              end else if (ld) begin
                m_cnt[i] = lv; m_sh[i] = lv;
              end
            end
          end
        endcase
      end
    end
  endtask

  function automatic logic [18:0] expv(input int i);
    bit r;
    r = (m_mode[i] == M_RUN);
    return {to_bcd(m_cnt[i]), r, r, m_done[i]};
  endfunction

  task automatic step(input bit cn, input bit tk, input bit ld, input logic [15:0] d,
                      input bit s, input bit p, input bit a);
    @(negedge clk);
    clear_n = cn; tick = tk; load = ld; start = s; pause = p; abort = a;
    {load_mt, load_mu, load_st, load_su} = d;
    @(posedge clk);
    model(cn, tk, ld, d, s, p, a);
    #1;
    n_done0 += int'(done0);
    n_done1 += int'(done1);
    chk("dut0_state", 32'({mt0, mu0, st0, su0, running0, valve0, done0}), 32'(expv(0)));
    chk("dut1_state", 32'({mt1, mu1, st1, su1, running1, valve1, done1}), 32'(expv(1)));
  endtask

  initial begin
    int d0;
    logic [15:0] rd;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_cnt[i] = 0; m_sh[i] = 0; m_done[i] = 1'b0;
    end

    // reset
    step(0, 0, 0, 16'h0000, 0, 0, 0);
    step(0, 1, 1, 16'h1234, 1, 0, 0);
    chk("reset_out", 32'({mt0, mu0, st0, su0, running0, valve0, done0}), 32'h0);

    // 00:12 countdown, single done pulse
    step(1, 0, 1, 16'h0012, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 1, 0, 0);
    chk("t1_running", 32'(running0), 32'd1);
    d0 = n_done0;
    for (int k = 0; k < 12; k++) begin
      step(1, 1, 0, 16'h0000, 0, 0, 0);
      step(1, 0, 0, 16'h0000, 0, 0, 0);
    end
    chk("t1_done_count", 32'(n_done0 - d0), 32'd1);
    chk("t1_valve_off", 32'({valve0, mt0, mu0, st0, su0}), 32'h0);

    // 10:00 triple borrow then full run
    step(1, 0, 0, 16'h0000, 0, 0, 1);
    step(1, 0, 1, 16'h1000, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 1, 0, 0);
    step(1, 1, 0, 16'h0000, 0, 0, 0);
    chk("t2_borrow", 32'({mt0, mu0, st0, su0}), 32'h0959);
    d0 = n_done0;
    for (int k = 0; k < 599; k++) step(1, 1, 0, 16'h0000, 0, 0, 0);
    chk("t2_done", 32'(n_done0 - d0), 32'd1);

    // pause with coincident tick
    step(1, 0, 0, 16'h0000, 0, 0, 1);
    step(1, 0, 1, 16'h0005, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 1, 0, 0);
    step(1, 1, 0, 16'h0000, 0, 1, 0);
    chk("t3_paused", 32'({mt0, mu0, st0, su0, running0}), 32'({16'h0005, 1'b0}));
    step(1, 0, 0, 16'h0000, 1, 0, 0);
    step(1, 1, 0, 16'h0000, 0, 0, 0);
    chk("t3_resume", 32'({mt0, mu0, st0, su0, running0}), 32'({16'h0004, 1'b1}));

    // clamp, start at zero
    step(1, 0, 0, 16'h0000, 0, 0, 1);
    step(1, 0, 1, 16'h7A9F, 0, 0, 0);
    chk("t4_clamp", 32'({mt0, mu0, st0, su0}), 32'h5959);
    step(1, 0, 0, 16'h0000, 0, 0, 1);
    step(1, 0, 0, 16'h0000, 1, 0, 0);
    chk("t4_start_zero", 32'({running0, mt0, mu0, st0, su0}), 32'h0);

    // abort and mid-run clear
    d0 = n_done0;
    step(1, 0, 1, 16'h0320, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 1, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 0, 1);
    chk("t5_abort", 32'({running0, mt0, mu0, st0, su0}), 32'h0);
    chk("t5_no_done", 32'(n_done0 - d0), 32'd0);
    step(1, 0, 1, 16'h0320, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 1, 0, 0);
    step(1, 1, 0, 16'h0000, 0, 0, 0);
    step(0, 1, 0, 16'h0000, 0, 0, 0);
    chk("t5_clear", 32'({mt0, mu0, st0, su0, running0, valve0, done0}), 32'h0);

    // auto-reload cadence
    step(1, 0, 1, 16'h0003, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 1, 0, 0);
    d0 = n_done1;
    for (int k = 0; k < 16; k++) step(1, 1, 0, 16'h0000, 0, 0, 0);
    chk("t6_reload_dones", 32'(n_done1 - d0), 32'd4);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rd = 16'($urandom);
      else rd = {8'h00, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      step($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, rd, $urandom_range(0, 7) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
